// File: rtl/fir_pkg.sv
// Shared FIR filter definitions: sample width/type, pipeline warm-up length, width helper.
package fir_pkg;

  localparam int unsigned DATA_W     = 24;
  localparam int unsigned N_TAPS     = 33;
  localparam int unsigned FIR_WARMUP = N_TAPS - 1;

  typedef logic signed [DATA_W-1:0] sample_t;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fir_sample_fifo.sv
// First-word-fall-through sample FIFO; pointers carry an extra wrap bit to split full from empty.
module fir_sample_fifo #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the slot in the same edge, so a full FIFO can still take a push.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/fir_decim_fifo.sv
// Drops FIR pipeline-fill samples, decimates by DECIM and buffers kept samples for the sink.
// Optional drop_count output enabled by defining FIR_DECIM_FIFO_STATS_EN.
module fir_decim_fifo #(
  parameter int unsigned DATA_W = fir_pkg::DATA_W,
  parameter int unsigned DECIM  = 4,
  parameter int unsigned WARMUP = fir_pkg::FIR_WARMUP,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_en,
  input  logic [DATA_W-1:0]        data_in,
  input  logic                     clear,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
`ifdef FIR_DECIM_FIFO_STATS_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int unsigned WarmW = fir_pkg::cnt_w(WARMUP);
  localparam int unsigned PhW   = fir_pkg::cnt_w(DECIM - 1);

  localparam logic StWarm = 1'b0;
  localparam logic StRun  = 1'b1;
  localparam logic StInit = (WARMUP == 0) ? StRun : StWarm;

  logic              state_q, state_d;
  logic [WarmW-1:0]  warm_q, warm_d;
  logic [PhW-1:0]    phase_q, phase_d;
  logic              overflow_q, overflow_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              accept, keep, drop;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;

  assign accept = in_en & ~clear;
  assign keep   = accept & (state_q == StRun) & (phase_q == '0);
  // A full FIFO always holds a head, so only a missing out_ready blocks the push.
  assign drop   = keep & fifo_full & ~out_ready;

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    phase_d = phase_q;
    if (clear) begin
      state_d = StInit;
      warm_d  = '0;
      phase_d = '0;
    end else if (accept) begin
      if (state_q == StWarm) begin
        warm_d = warm_q + 1'b1;
        if (warm_d == WarmW'(WARMUP)) state_d = StRun;
      end else if (DECIM > 1) begin
        phase_d = (phase_q == PhW'(DECIM - 1)) ? '0 : phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    overflow_d = clear ? 1'b0 : (overflow_q | drop);
    // Hold the last presented head while the FIFO is empty.
    out_data_d = fifo_empty ? out_data_q : fifo_rdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StInit;
      warm_q     <= '0;
      phase_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      warm_q     <= warm_d;
      phase_q    <= phase_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  fir_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (clear),
    .push    (keep),
    .pop     (out_ready),
    .wdata   (data_in),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (level)
  );

  assign out_valid = ~fifo_empty;
  assign out_data  = out_data_d;
  assign overflow  = overflow_q;

`ifdef FIR_DECIM_FIFO_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (clear)                             drop_cnt_d = '0;
    else if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Bench for fir_decim_fifo: two configurations share stimulus and are checked against a list model.
module tb_fir_decim_fifo;

  localparam int unsigned DW = 24;
  localparam int unsigned DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_en, clear, out_ready;
  logic [DW-1:0] data_in;

  logic          a_valid, b_valid, a_ovf, b_ovf;
  logic [DW-1:0] a_data, b_data;
  logic [3:0]    a_level, b_level;
  logic [15:0]   a_dc, b_dc;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fir_decim_fifo #(.DATA_W(DW), .DECIM(1), .WARMUP(32), .DEPTH(DEPTH)) u_a (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_en     (in_en),
    .data_in   (data_in),
    .clear     (clear),
    .out_valid (a_valid),
    .out_data  (a_data),
    .out_ready (out_ready),
    .level     (a_level),
    .overflow  (a_ovf)
`ifdef FIR_DECIM_FIFO_STATS_EN
    ,
    .drop_count (a_dc)
`endif
  );

  fir_decim_fifo #(.DATA_W(DW), .DECIM(4), .WARMUP(0), .DEPTH(DEPTH)) u_b (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_en     (in_en),
    .data_in   (data_in),
    .clear     (clear),
    .out_valid (b_valid),
    .out_data  (b_data),
    .out_ready (out_ready),
    .level     (b_level),
    .overflow  (b_ovf)
`ifdef FIR_DECIM_FIFO_STATS_EN
    ,
    .drop_count (b_dc)
`endif
  );

`ifndef FIR_DECIM_FIFO_STATS_EN
  assign a_dc = '0;
  assign b_dc = '0;
`endif

  // Reference model: sample index since clear decides keep; FIFO is a plain list.
  int            m_dec  [2] = '{1, 4};
  int            m_warm [2] = '{32, 0};
  int            m_nacc [2];
  int            m_cnt  [2];
  int            m_drops[2];
  bit            m_ovf  [2];
  logic [DW-1:0] m_last [2];
  logic [DW-1:0] m_mem  [2][DEPTH];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_nacc[k] = 0; m_cnt[k] = 0; m_drops[k] = 0; m_ovf[k] = 0; m_last[k] = '0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      if (clear) begin
        m_nacc[k] = 0; m_cnt[k] = 0; m_drops[k] = 0; m_ovf[k] = 0;
      end else begin
        bit pop;
        bit kept;
        pop  = (m_cnt[k] > 0) && out_ready;
        kept = 0;
        if (in_en) begin
          kept = (m_nacc[k] >= m_warm[k]) && (((m_nacc[k] - m_warm[k]) % m_dec[k]) == 0);
          m_nacc[k]++;
        end
        if (pop) begin
          for (int i = 0; i < DEPTH - 1; i++) m_mem[k][i] = m_mem[k][i+1];
          m_cnt[k]--;
        end
        if (kept) begin
          if (m_cnt[k] < DEPTH) begin
            m_mem[k][m_cnt[k]] = data_in;
            m_cnt[k]++;
          end else begin
            m_ovf[k] = 1;
            if (m_drops[k] < 65535) m_drops[k]++;
          end
        end
      end
      if (m_cnt[k] > 0) m_last[k] = m_mem[k][0];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_inst(input int k, input logic v, input logic [DW-1:0] d,
                            input logic [3:0] lv, input logic o, input logic [15:0] dc);
    string p;
    p = (k == 0) ? "a" : "b";
    chk({p, "_valid"}, 32'(v), 32'(m_cnt[k] > 0));
    chk({p, "_data"}, 32'(d), 32'((m_cnt[k] > 0) ? m_mem[k][0] : m_last[k]));
    chk({p, "_level"}, 32'(lv), 32'(m_cnt[k]));
    chk({p, "_overflow"}, 32'(o), 32'(m_ovf[k]));
`ifdef FIR_DECIM_FIFO_STATS_EN
    chk({p, "_drop_count"}, 32'(dc), 32'(m_drops[k]));
`else
    if (dc !== 16'h0) chk({p, "_drop_count_tied"}, 32'(dc), 32'h0);
`endif
  endtask

  task automatic check_all();
    check_inst(0, a_valid, a_data, a_level, a_ovf, a_dc);
    check_inst(1, b_valid, b_data, b_level, b_ovf, b_dc);
  endtask

  // Called at a negedge: drive, take the posedge, then check at the next negedge.
  task automatic cycle(input bit en, input logic [DW-1:0] d, input bit rdy, input bit clr);
    in_en = en; data_in = d; out_ready = rdy; clear = clr;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  logic [DW-1:0] got_b [8];
  logic [DW-1:0] exp_b [4] = '{24'd0, 24'd4, 24'd8, 24'd12};
  logic [DW-1:0] exp_a [8] = '{24'd101, 24'd102, 24'd103, 24'd104,
                               24'd105, 24'd106, 24'd107, 24'h7FFFFF};
  int nb;

  initial begin
    reset_n = 1'b1; in_en = 0; clear = 0; out_ready = 0; data_in = '0;
    model_reset();
    #2 reset_n = 1'b0;
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;

    // Decimation by 4 on u_b with idle gaps between samples.
    nb = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1, DW'(i), 1, 0);
      if (b_valid && nb < 8) begin got_b[nb] = b_data; nb++; end
      cycle(0, 24'hABCDEF, 1, 0);
      if (b_valid && nb < 8) begin got_b[nb] = b_data; nb++; end
    end
    chk("gap_count", 32'(nb), 32'd4);
    for (int i = 0; i < 4; i++) chk("gap_seq", 32'(got_b[i]), 32'(exp_b[i]));

    // Warm-up discard on u_a: 1..32 dropped, 33.. kept.
    cycle(0, '0, 1, 1);
    for (int i = 1; i <= 40; i++) begin
      cycle(1, DW'(i), 1, 0);
      if (i == 32) chk("warm_empty", 32'(a_valid), 32'd0);
      if (i == 33) chk("warm_first", 32'(a_data), 32'd33);
    end
    for (int i = 0; i < 3; i++) cycle(0, '0, 1, 0);

    // Overflow: 10 pushes into 8 slots with no pops.
    for (int i = 0; i < 10; i++) cycle(1, DW'(100 + i), 0, 0);
    chk("ovf_level", 32'(a_level), 32'd8);
    chk("ovf_flag", 32'(a_ovf), 32'd1);
`ifdef FIR_DECIM_FIFO_STATS_EN
    chk("ovf_drops", 32'(a_dc), 32'd2);
`endif

    // Push with pop at full keeps level and drop count.
    cycle(1, 24'h7FFFFF, 1, 0);
    chk("fullpp_level", 32'(a_level), 32'd8);
`ifdef FIR_DECIM_FIFO_STATS_EN
    chk("fullpp_drops", 32'(a_dc), 32'd2);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("drain_seq", 32'(a_data), 32'(exp_a[i]));
      cycle(0, '0, 1, 0);
    end
    chk("drain_empty", 32'(a_valid), 32'd0);

    // Signed extremes, bit-exact.
    cycle(1, 24'h800000, 0, 0);
    cycle(1, 24'hFFFFFF, 0, 0);
    chk("signed_min", 32'(a_data), 32'h800000);
    cycle(0, '0, 1, 0);
    chk("signed_neg1", 32'(a_data), 32'hFFFFFF);
    cycle(0, '0, 1, 0);
    chk("hold_last", 32'(a_data), 32'hFFFFFF);

    // Clear mid-stream with level 5 and overflow set, plus a kept input.
    for (int i = 0; i < 5; i++) cycle(1, DW'(200 + i), 0, 0);
    chk("pre_clear_level", 32'(a_level), 32'd5);
    cycle(1, 24'h123456, 1, 1);
    chk("clear_level", 32'(a_level), 32'd0);
    chk("clear_ovf", 32'(a_ovf), 32'd0);
    for (int i = 0; i < 32; i++) cycle(1, DW'(300 + i), 1, 0);
    chk("rewarm_empty", 32'(a_valid), 32'd0);
    cycle(1, 24'd999, 1, 0);
    chk("rewarm_first", 32'(a_data), 32'd999);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 9) < 7), DW'($urandom), bit'($urandom_range(0, 1)),
            bit'($urandom_range(0, 59) == 0));

    // Asynchronous reset between edges.
    in_en = 1; data_in = DW'($urandom); out_ready = 0; clear = 0;
    #2 reset_n = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 60; i++)
      cycle(1, DW'($urandom), bit'($urandom_range(0, 3) == 0), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
